alu32_pass_sequencer: RTL

Initiator-side controller for the existing combinational 16-bit ALU (FS[4:0], A, B, Cin in; F, Cout out). It accepts 32-bit operation requests over a valid/ready command port. Each request runs as two ALU passes, low half then high half, with carry and shift-bit chaining between them. The 32-bit result is returned over a valid/ready response port. The block sits between the processor control path and the shared ALU instance.

---
 rtl/alu32_pass_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu32_pass_sequencer.sv
// alu32_pass_sequencer
//   Runs a 32-bit ALU request as two passes through a shared 16-bit
//   combinational ALU: the low half first, then the high half. Carry and
//   shift bits are chained between the two passes.
//
//   Optional build macro: ALUSEQ_OVERFLOW_EN adds the rsp_ovf output.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready  request handshake (ready only while idle)
//   cmd_fs/a/b/cin       request: function select, operands, carry-in
//   alu_fs/a/b/cin       drive to the shared ALU (zero when no pass is active)
//   alu_f/alu_cout       ALU result and carry-out
//   rsp_valid/rsp_ready  response handshake
//   rsp_f/rsp_cout       32-bit result, final carry or shifted-out bit
//   rsp_ovf              signed overflow for add/subtract (optional)
module alu32_pass_sequencer #(
   parameter int unsigned HALF_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [4:0]            cmd_fs,
   input  logic [2*HALF_W-1:0]   cmd_a,
   input  logic [2*HALF_W-1:0]   cmd_b,
   input  logic                  cmd_cin,
   output logic [4:0]            alu_fs,
   output logic [HALF_W-1:0]     alu_a,
   output logic [HALF_W-1:0]     alu_b,
   output logic                  alu_cin,
   input  logic [HALF_W-1:0]     alu_f,
   input  logic                  alu_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*HALF_W-1:0]   rsp_f,
   output logic                  rsp_cout
`ifdef ALUSEQ_OVERFLOW_EN
   ,
   output logic                  rsp_ovf
`endif
);

   localparam int unsigned W = 2 * HALF_W;

   localparam logic [4:0] FS_ADD_CIN = 5'b10000;
   localparam logic [4:0] FS_NEG     = 5'b10001;
   localparam logic [4:0] FS_INC     = 5'b10010;
   localparam logic [4:0] FS_CIN_SUB = 5'b10011;
   localparam logic [4:0] FS_ADD     = 5'b10100;
   localparam logic [4:0] FS_NOTA_B  = 5'b10101;
   localparam logic [4:0] FS_SUB     = 5'b10110;

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

   state_t              state, next_state;
   logic [4:0]          fs_q;
   logic [W-1:0]        a_q, b_q;
   logic                cin_q;
   logic [HALF_W-1:0]   res_lo, res_hi;
   logic                c_lo;
   logic                cout_q;
   logic                ovf_q;

   logic is_logic, is_shl, is_shr, is_neg, is_inc;

   assign is_logic = ~fs_q[4];
   assign is_shl   = (fs_q[4:3] == 2'b11) & ~fs_q[0];
   assign is_shr   = (fs_q[4:3] == 2'b11) &  fs_q[0];
   assign is_neg   = (fs_q == FS_NEG) | (fs_q == FS_CIN_SUB);
   assign is_inc   = (fs_q == FS_INC);

   assign cmd_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign rsp_f     = {res_hi, res_lo};
   assign rsp_cout  = cout_q;
`ifdef ALUSEQ_OVERFLOW_EN
   assign rsp_ovf   = ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      alu_fs     = '0;
      alu_a      = '0;
      alu_b      = '0;
      alu_cin    = 1'b0;
      unique case (state)
         S_IDLE: if (cmd_valid) next_state = S_LO;
         S_LO: begin
            alu_fs     = fs_q;
            alu_a      = a_q[HALF_W-1:0];
            alu_b      = b_q[HALF_W-1:0];
            alu_cin    = is_logic ? 1'b0 : cin_q;
            next_state = S_HI;
         end
         S_HI: begin
            alu_fs  = fs_q;
            alu_a   = a_q[W-1:HALF_W];
            alu_b   = b_q[W-1:HALF_W];
            alu_cin = c_lo;
            if (is_logic) alu_cin = 1'b0;
            // A+1+Cin: the +1 belongs to the low half only.
            if (is_inc) alu_fs = FS_ADD_CIN;
            // Negations continue as ~A_hi + carry.
            if (is_neg) begin
               alu_fs = FS_NOTA_B;
               alu_b  = '0;
            end
            if (is_shl) alu_cin = a_q[HALF_W-1];
            // Shift right: the upper half takes the request carry-in as its MSB.
            if (is_shr) alu_cin = cin_q;
            next_state = S_RESP;
         end
         S_RESP: if (rsp_ready) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fs_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cin_q  <= 1'b0;
         res_lo <= '0;
         res_hi <= '0;
         c_lo   <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (cmd_valid) begin
               fs_q  <= cmd_fs;
               a_q   <= cmd_a;
               b_q   <= cmd_b;
               cin_q <= cmd_cin;
            end
            S_LO: begin
               // Shift right: the low half's MSB comes from the high half's LSB.
               res_lo <= is_shr ? {a_q[HALF_W], alu_f[HALF_W-2:0]} : alu_f;
               c_lo   <= alu_cout;
            end
            S_HI: begin
               res_hi <= alu_f;
               if (is_logic)    cout_q <= 1'b0;
               else if (is_shl) cout_q <= a_q[W-1];
               else if (is_shr) cout_q <= a_q[0];
               else             cout_q <= alu_cout;
               if (fs_q == FS_ADD)
                  ovf_q <= (a_q[W-1] == b_q[W-1]) & (alu_f[HALF_W-1] != a_q[W-1]);
               else if (fs_q == FS_SUB)
                  ovf_q <= (a_q[W-1] != b_q[W-1]) & (alu_f[HALF_W-1] != a_q[W-1]);
               else
                  ovf_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
